// File: rtl/read_result_1_pkg.sv
// Shared FC readout parameters and readout FSM state encodings.
package read_result_1_pkg;

  localparam int unsigned DATA_WIDTH_FC                = 16;
  localparam int unsigned FC_OUTNEURON_ADDR_WIDTH      = 9;
  localparam int unsigned FC_COUNT_OUT_NEURON_BITWIDTH = 4;
  localparam int unsigned OUTNEURON                    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/read_result_1_fc_result_fifo.sv
// Small synchronous FIFO buffering {value, index} entries between the RAM read port and the stream.
module fc_result_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Callers guarantee no push when full; popping an empty FIFO is ignored.
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/read_result_1.sv
// Streams FC output-neuron results from RAM in index order and tracks the argmax class.
module read_result_1 import read_result_1_pkg::*; #(
  parameter int unsigned DATA_WIDTH_FC                = read_result_1_pkg::DATA_WIDTH_FC,
  parameter int unsigned FC_OUTNEURON_ADDR_WIDTH      = read_result_1_pkg::FC_OUTNEURON_ADDR_WIDTH,
  parameter int unsigned FC_COUNT_OUT_NEURON_BITWIDTH = read_result_1_pkg::FC_COUNT_OUT_NEURON_BITWIDTH,
  parameter int unsigned OUTNEURON                    = read_result_1_pkg::OUTNEURON,
  parameter int unsigned FIFO_DEPTH                   = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    fc_outneuron_rden,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]      fc_outneuron_address,
  input  logic [DATA_WIDTH_FC-1:0]                fc_outneuron_q,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH_FC-1:0]                out_data,
  output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] out_index,
  output logic                                    out_last,
  output logic                                    class_valid,
  output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] class_index,
  output logic [DATA_WIDTH_FC-1:0]                class_score
);

  localparam int unsigned CNT_W   = FC_COUNT_OUT_NEURON_BITWIDTH;
  localparam int unsigned ADDR_W  = FC_OUTNEURON_ADDR_WIDTH;
  localparam int unsigned PTR_W   = CNT_W + 1;
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = DATA_WIDTH_FC + CNT_W;

  state_t              state;
  state_t              state_nxt;
  logic [PTR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]   addr_hold;
  logic                inflight;
  logic [CNT_W-1:0]    inflight_index;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W:0]      credit_used;
  logic [ENTRY_W-1:0]  head;
  logic                issue;
  logic                last_issue;
  logic                beat;

  // A read is only issued when the FIFO is guaranteed room for its data next cycle.
  assign credit_used = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight);
  assign issue       = (state == READ) && (credit_used < (OCC_W+1)'(FIFO_DEPTH));
  assign last_issue  = issue && (rd_ptr == PTR_W'(OUTNEURON - 1));

  assign fc_outneuron_rden    = issue;
  assign fc_outneuron_address = issue ? ADDR_W'(rd_ptr) : addr_hold;

  assign out_valid             = (occ != '0);
  assign {out_data, out_index} = head;
  assign out_last              = out_valid && (out_index == CNT_W'(OUTNEURON - 1));
  assign beat                  = out_valid && out_ready;

  assign busy        = (state != IDLE);
  assign class_valid = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (beat && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read pointer, in-flight tracking and running argmax.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr         <= '0;
      addr_hold      <= '0;
      inflight       <= 1'b0;
      inflight_index <= '0;
      class_index    <= '0;
      class_score    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_index <= CNT_W'(rd_ptr);
        addr_hold      <= ADDR_W'(rd_ptr);
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end else if ((state == IDLE) && start) begin
        rd_ptr <= '0;
      end
      // Strictly-greater replacement keeps the lowest index on ties.
      if (beat && ((out_index == '0) || ($signed(out_data) > $signed(class_score)))) begin
        class_index <= out_index;
        class_score <= out_data;
      end
    end
  end

  fc_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data ({fc_outneuron_q, inflight_index}),
    .pop       (beat),
    .pop_data  (head),
    .count     (occ)
  );

endmodule

// File: tb/tb_read_result_1.sv
// Directed bench for read_result_1: table of RAM layers plus reset and back-to-back sequences.
module tb_read_result_1;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 4;
  localparam int unsigned N  = 10;
  localparam int unsigned FD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          fc_outneuron_rden;
  logic [AW-1:0] fc_outneuron_address;
  logic [DW-1:0] fc_outneuron_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_index;
  logic          out_last;
  logic          class_valid;
  logic [CW-1:0] class_index;
  logic [DW-1:0] class_score;

  read_result_1 dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .busy                 (busy),
    .fc_outneuron_rden    (fc_outneuron_rden),
    .fc_outneuron_address (fc_outneuron_address),
    .fc_outneuron_q       (fc_outneuron_q),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_index            (out_index),
    .out_last             (out_last),
    .class_valid          (class_valid),
    .class_index          (class_index),
    .class_score          (class_score)
  );

  always #5 clock = ~clock;

  // Output-neuron RAM model: one-cycle read latency.
  logic [DW-1:0] ram [16];
  always @(posedge clock) if (fc_outneuron_rden) fc_outneuron_q <= ram[fc_outneuron_address[3:0]];

  typedef struct packed {
    logic [N-1:0][DW-1:0] v;
    logic [CW-1:0]        cls;
    logic [DW-1:0]        score;
    logic                 bp;
    logic [7:0]           restart_at;
  } vec_t;

  vec_t tbl [5];
  int   vals [5][10] = '{
    '{5, -3, 100, 7, 100, 0, -128, 42, 1, 2},
    '{-10, -11, -12, -13, -14, -15, -16, -17, -18, -19},
    '{3, 9, -1, 9, 20, 20, -5, 19, 0, -20},
    '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10},
    '{-1, 0, 0, 0, 0, 0, 0, 32767, -32768, 32767}
  };

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Runs one layer from the start pulse through the cycle after class_valid.
  task automatic run_layer(input vec_t v, input bit chk_hold, input logic [CW-1:0] pidx,
                           input logic [DW-1:0] pscore);
    int cyc = 1, exp_idx = 0, first_cyc = -1, last_cyc = -1, occ_m = 0;
    bit rden_d1 = 0, rden_d2 = 0, pop_d1 = 0, pop_now, stalled = 0, done = 0;
    logic [DW-1:0] held_d;
    logic [CW-1:0] held_i;
    for (int i = 0; i < int'(N); i++) ram[i] = v.v[i];
    start = 1'b1;
    out_ready = v.bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!done && cyc < 400) begin
      if (v.restart_at != 0) start = (cyc == int'(v.restart_at));
      out_ready = v.bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      occ_m = occ_m + int'(rden_d2) - int'(pop_d1);
      if (out_valid !== (occ_m != 0)) check("valid_vs_occ", 64'(out_valid), 64'(occ_m != 0));
      if (occ_m > int'(FD)) check("occ_bound", 64'(occ_m), 64'(FD));
      if (occ_m + int'(rden_d1) == int'(FD)) check("credit_stall", 64'(fc_outneuron_rden), 64'd0);
      if (cyc == 1 && !v.bp) check("first_read", {fc_outneuron_rden, 7'd0, fc_outneuron_address}, {1'b1, 16'd0});
      if (chk_hold && cyc <= 2) check("class_hold", {class_index, class_score}, {pidx, pscore});
      if (stalled) check("stall_stable", {out_index, out_data}, {held_i, held_d});
      stalled = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_idx >= int'(N)) check("extra_beat", 64'(exp_idx), 64'(N - 1));
          else begin
            check("beat", {out_last, out_index, out_data},
                  {(exp_idx == int'(N - 1)), CW'(exp_idx), v.v[exp_idx]});
          end
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          exp_idx++;
        end else begin
          stalled = 1;
          held_d = out_data;
          held_i = out_index;
        end
      end
      if (class_valid) begin
        check("class_timing", 64'(cyc), 64'(last_cyc + 1));
        check("beat_count", 64'(exp_idx), 64'(N));
        check("class_result", {class_index, class_score}, {v.cls, v.score});
        done = 1;
      end
      pop_now = out_valid && out_ready;
      rden_d2 = rden_d1;
      rden_d1 = fc_outneuron_rden;
      pop_d1 = pop_now;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (!done) check("layer_timeout", 64'd0, 64'd1);
    check("after_done", {class_valid, busy}, 2'b00);
    if (!v.bp) check("stream_window", {32'(first_cyc), 32'(last_cyc)}, {32'd3, 32'(N + 2)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < int'(N); i++) tbl[k].v[i] = DW'(vals[k][i]);
      tbl[k].bp = 1'b0;
      tbl[k].restart_at = 8'd0;
    end
    tbl[0].cls = 4'd2; tbl[0].score = 16'd100;
    tbl[1].cls = 4'd0; tbl[1].score = 16'hFFF6;
    tbl[2].cls = 4'd4; tbl[2].score = 16'd20;   tbl[2].bp = 1'b1;
    tbl[3].cls = 4'd9; tbl[3].score = 16'd10;   tbl[3].restart_at = 8'd6;
    tbl[4].cls = 4'd7; tbl[4].score = 16'h7FFF;

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    repeat (2) @(negedge clock);
    check("reset_outputs", {busy, fc_outneuron_rden, fc_outneuron_address, out_valid, out_data,
                            out_index, out_last, class_valid, class_index, class_score}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Layers run back to back: each start lands the cycle after the previous class_valid.
    for (int k = 0; k < 5; k++) begin
      if (k == 0) run_layer(tbl[k], 1'b1, '0, '0);
      else        run_layer(tbl[k], 1'b1, tbl[k-1].cls, tbl[k-1].score);
    end

    // Reset in the middle of the read phase.
    for (int i = 0; i < int'(N); i++) ram[i] = tbl[0].v[i];
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("rden_before_reset", 64'(fc_outneuron_rden), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", {busy, fc_outneuron_rden, fc_outneuron_address, out_valid, out_data,
                                out_index, out_last, class_valid, class_index, class_score}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("quiet_after_reset", {out_valid, busy, fc_outneuron_rden}, 3'b000);
      @(negedge clock);
    end
    run_layer(tbl[0], 1'b1, '0, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
